// File: rtl/gpioemu_mulx_if.sv
// rtl/gpioemu_mulx_if.sv - srd/swr register bus for gpioemu_mulx
//
// Purpose: groups the emulated system-bus signals of the multiplier
// peripheral so the peripheral and its bus master share one definition.
//
// Signals:
//   saddress   32      bus address
//   srd        1       read strobe (level)
//   swr        1       write strobe (level)
//   sdata_in   DATA_W  write data
//   sdata_out  DATA_W  registered read data, driven by the peripheral
//
// Modports:
//   master  drives address, strobes and write data; samples sdata_out
//   slave   the peripheral side

interface gpioemu_mulx_if #(
   parameter int DATA_W = 32
);
   logic [31:0]       saddress;
   logic              srd;
   logic              swr;
   logic [DATA_W-1:0] sdata_in;
   logic [DATA_W-1:0] sdata_out;

   modport master (
      output saddress,
      output srd,
      output swr,
      output sdata_in,
      input  sdata_out
   );

   modport slave (
      input  saddress,
      input  srd,
      input  swr,
      input  sdata_in,
      output sdata_out
   );
endinterface

// File: rtl/gpioemu_mulx.sv
// rtl/gpioemu_mulx.sv - memory-mapped shift-add multiplier with popcount and irq
//
// Purpose: multiplies operands A1 and A2 written over the srd/swr bus using
// a one-bit-per-cycle shift-add datapath, then publishes the product W, its
// population count L and a status word B. Raises a level irq on completion
// when CTRL.IE is set; reading B clears the pending interrupt.
//
// Register map (index k at BASE_ADDR + k*ADDR_STRIDE):
//   0 A1 RW | 1 A2 RW, write starts | 2 W RO | 3 L RO | 4 B RO | 5 CTRL RW (bit0 IE)
//   B = {VALID, A2_BIG, A1_BIG, BUSY, OVF} in bits [4:0]
//
// Ports:
//   clk       system clock, all state on posedge
//   n_reset   asynchronous active-low reset
//   bus       gpioemu_mulx_if.slave (saddress, srd, swr, sdata_in, sdata_out)
//   irq       completion interrupt, level
//   gpio_out  product mirror
//
// Build option: define GPIOEMU_MULX_GPIO_MIRROR_EN to make gpio_out follow W
// at each completion; otherwise gpio_out is tied to 0.

module gpioemu_mulx #(
   parameter int          DATA_W      = 32,
   parameter int          ARG_W       = 24,
   parameter logic [31:0] BASE_ADDR   = 32'h2C8,
   parameter int          ADDR_STRIDE = 8
) (
   input  logic              clk,
   input  logic              n_reset,
   gpioemu_mulx_if.slave     bus,
   output logic              irq,
   output logic [DATA_W-1:0] gpio_out
);
   localparam int          PW     = 2 * ARG_W;
   localparam int          LW     = $clog2(DATA_W + 1);
   localparam int          CW     = $clog2(ARG_W + 1);
   localparam logic [31:0] STRIDE = 32'(ADDR_STRIDE);
   localparam logic [CW-1:0] LAST = CW'(ARG_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_CNT
   } state_t;

   state_t state_q, state_d;

   // Strobes, address and data are registered together so the decode in the
   // edge cycle sees the address that accompanied the strobe.
   logic              srd_q, srd_qq, swr_q, swr_qq;
   logic [31:0]       addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic [DATA_W-1:0] a1, a2, w;
   logic [LW-1:0]     l;
   logic              ovf, a1_big, a2_big, valid, ie, irq_pend;

   logic [PW-1:0]     acc, mcand;
   logic [ARG_W-1:0]  mplier;
   logic [CW-1:0]     cnt;

   logic              wr_ev, rd_ev, hit;
   logic [31:0]       off, slot;
   logic [2:0]        idx;
   logic              wr_a1, wr_a2, wr_ctrl, rd_b;
   logic              a1_big_new, a2_big_new, start, abort, done, busy;
   logic [PW+DATA_W-1:0] acc_wide;
   logic [DATA_W-1:0] w_next;
   logic              ovf_next;
   logic [LW-1:0]     pop;
   logic [DATA_W-1:0] rd_data;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         srd_q   <= 1'b0;
         srd_qq  <= 1'b0;
         swr_q   <= 1'b0;
         swr_qq  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         srd_q   <= bus.srd;
         srd_qq  <= srd_q;
         swr_q   <= bus.swr;
         swr_qq  <= swr_q;
         addr_q  <= bus.saddress;
         wdata_q <= bus.sdata_in;
      end
   end

   // A write edge wins over a read edge arriving in the same cycle.
   assign wr_ev = swr_q & ~swr_qq;
   assign rd_ev = srd_q & ~srd_qq & ~wr_ev;

   assign off  = addr_q - BASE_ADDR;
   assign slot = off / STRIDE;
   assign hit  = (addr_q >= BASE_ADDR) && ((off % STRIDE) == 32'd0) && (slot < 32'd6);
   assign idx  = slot[2:0];

   assign wr_a1   = wr_ev & hit & (idx == 3'd0);
   assign wr_a2   = wr_ev & hit & (idx == 3'd1);
   assign wr_ctrl = wr_ev & hit & (idx == 3'd5);
   assign rd_b    = rd_ev & hit & (idx == 3'd4);

   assign a1_big_new = |(wdata_q >> ARG_W);
   assign a2_big_new = |(wdata_q >> ARG_W);

   // Any operand write either restarts the multiply or drops back to idle.
   assign start = wr_a2 & ~a1_big & ~a2_big_new;
   assign abort = (wr_a1 | wr_a2) & ~start;
   assign busy  = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      if (start) begin
         state_d = S_MUL;
      end else if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_MUL: if (cnt == LAST) state_d = S_CNT;
            S_CNT: begin
               state_d = S_IDLE;
               done    = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Zero-extending past DATA_W makes the overflow test valid even when the
   // accumulator is narrower than the bus.
   assign acc_wide = {{DATA_W{1'b0}}, acc};
   assign w_next   = acc_wide[DATA_W-1:0];
   assign ovf_next = |(acc_wide >> DATA_W);

   always_comb begin
      pop = '0;
      for (int i = 0; i < DATA_W; i++) pop = pop + LW'(w_next[i]);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         a1       <= '0;
         a2       <= '0;
         w        <= '0;
         l        <= '0;
         ovf      <= 1'b0;
         a1_big   <= 1'b0;
         a2_big   <= 1'b0;
         valid    <= 1'b0;
         ie       <= 1'b0;
         irq_pend <= 1'b0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
      end else begin
         if (wr_a1) begin
            a1       <= wdata_q;
            a1_big   <= a1_big_new;
            valid    <= 1'b0;
            ovf      <= 1'b0;
            irq_pend <= 1'b0;
         end
         if (wr_a2) begin
            a2       <= wdata_q;
            a2_big   <= a2_big_new;
            valid    <= 1'b0;
            ovf      <= 1'b0;
            irq_pend <= 1'b0;
         end
         if (wr_ctrl) ie <= wdata_q[0];
         if (rd_b) irq_pend <= 1'b0;

         if (start) begin
            acc    <= '0;
            mcand  <= PW'(a1[ARG_W-1:0]);
            mplier <= wdata_q[ARG_W-1:0];
            cnt    <= '0;
         end else if (state_q == S_MUL) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
         end

         if (done) begin
            w        <= w_next;
            l        <= pop;
            ovf      <= ovf_next;
            valid    <= 1'b1;
            irq_pend <= 1'b1;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (hit) begin
         case (idx)
            3'd0:    rd_data = a1;
            3'd1:    rd_data = a2;
            3'd2:    rd_data = w;
            3'd3:    rd_data = DATA_W'(l);
            3'd4:    rd_data = DATA_W'({valid, a2_big, a1_big, busy, ovf});
            3'd5:    rd_data = DATA_W'(ie);
            default: rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         bus.sdata_out <= '0;
         irq           <= 1'b0;
      end else begin
         if (rd_ev) bus.sdata_out <= rd_data;
         irq <= valid & ie & irq_pend;
      end
   end

`ifdef GPIOEMU_MULX_GPIO_MIRROR_EN
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)  gpio_out <= '0;
      else if (done) gpio_out <= w_next;
   end
`else
   assign gpio_out = '0;
`endif

endmodule

// File: doc/gpioemu_mulx.md
Name: gpioemu_mulx

Overview:
Parametrised successor to the gpioemu memory-mapped multiplier peripheral. It multiplies two operands written over the simple srd/swr bus with a sequential shift-add datapath. It publishes the product, the product's population count, and a status word, and can raise an interrupt on completion. It sits on the same emulated system bus as gpioemu and keeps its register offsets and status-bit meanings.

Parameters:
DATA_W, 32, bus data width and width of the W (product) register
ARG_W, 24, legal operand width; operands >= 2^ARG_W are rejected; must be <= DATA_W
BASE_ADDR, 32'h2C8, address of register index 0
ADDR_STRIDE, 8, byte distance between consecutive registers

Ports:
clk  input  1  system clock, all state on posedge
n_reset  input  1  asynchronous active-low reset
saddress  input  32  bus address
srd  input  1  read strobe, level, sampled on clk
swr  input  1  write strobe, level, sampled on clk
sdata_in  input  DATA_W  write data
sdata_out  output  DATA_W  registered read data
irq  output  1  completion interrupt, level
gpio_out  output  DATA_W  product mirror (see Optional Feature)

Behaviour:
- Register map (index k at BASE_ADDR + k*ADDR_STRIDE):
  - 0 A1: RW
  - 1 A2: RW; a write triggers a start
  - 2 W: RO, product low DATA_W bits
  - 3 L: RO, number of ones in W
  - 4 B: RO status
  - 5 CTRL: RW; bit0 = IE, other bits read 0
- Unmapped addresses: reads return 0, writes are ignored. Writes to RO registers are ignored.
- Strobe handling:
  - swr and srd are registered, and an access acts only on the first cycle a strobe is seen high (rising-edge detect). Holding a strobe high performs one access.
  - If srd and swr rise in the same cycle, the write is performed and the read is dropped.
- sdata_out: loaded one clk after the read edge is detected and held until the next read.
- Status B bits:
  - [0] OVF: product has nonzero bits above DATA_W-1
  - [1] BUSY
  - [2] A1_BIG
  - [3] A2_BIG
  - [4] VALID
  - all other bits 0
- Write A1:
  - Stores the value and sets A1_BIG = (value >= 2^ARG_W).
  - Clears VALID and OVF.
  - If BUSY, aborts the operation and returns to IDLE.
- Write A2:
  - Stores the value and sets A2_BIG similarly.
  - Clears VALID and OVF.
  - If A1_BIG or A2_BIG is set, no start: W and L hold, BUSY stays 0.
  - Otherwise enters MUL; this also restarts an operation in progress.
- FSM:
  - IDLE -> MUL on a legal start.
  - MUL runs ARG_W cycles, one multiplier bit per cycle, into a 2*ARG_W accumulator.
  - MUL -> CNT: one cycle; W <= acc[DATA_W-1:0], OVF <= |acc[2*ARG_W-1:DATA_W] (0 if 2*ARG_W <= DATA_W), L <= popcount(W).
  - CNT -> IDLE with VALID=1, BUSY=0.
- Latency: VALID rises ARG_W+2 clk after the A2 write edge is detected.
- BUSY is 1 in MUL and CNT. W and L keep their old values while BUSY.
- irq = VALID & IE, registered. Reading B clears the irq latch; VALID stays set. irq re-arms on the next completion.
- Reset (asynchronous, any state, including mid-MUL): all registers, the FSM (to IDLE), sdata_out, irq and gpio_out go to 0.

Optional Feature:
GPIOEMU_MULX_GPIO_MIRROR_EN:
- Defined: gpio_out loads W in the cycle VALID rises and holds until reset or the next completion.
- Undefined: gpio_out is constant 0, and the register and irq behaviour are unchanged.

Test Plan:
1. A1=2, A2=3, wait 26 clk -> W=6, L=2, B=0x10, irq=0.
2. A1=0x800000, A2=0x800001 -> W=0x00800000, L=1, B=0x11.
3. A1=0x01000000 -> B=0x04. Then A2=5 -> B=0x04, no BUSY. Then A1=0 -> B=0x00.
4. A1=0xA, A2=0xB, read B 3 clk after the write -> B=0x02. After completion -> W=0x6E, L=5, B=0x10.
5. CTRL=1, A1=A2=0xFFFFFF -> irq=1 at VALID, W=0xFE000001, L=8, B=0x11. Read B -> irq=0, B still 0x11. With the mirror macro defined, gpio_out=0xFE000001.
6. Start A1=7, A2=9, pull n_reset low at MUL cycle 10 -> all outputs 0 immediately. Release, rewrite -> W=0x3F, L=6, B=0x10.
